// File: rtl/zxuno_regport_pkg.sv
// Shared types and constants for the ZX-Uno register-port sequencer.
package zxuno_regport_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AWR,
    ST_AREAD,
    ST_DWR,
    ST_DREAD,
    ST_RELEASE
  } state_t;

  localparam logic [15:0] ZXUNO_ADDR_PORT = 16'hFC3B;
  localparam logic [15:0] ZXUNO_DATA_PORT = 16'hFD3B;
  localparam logic [7:0]  ZXUNO_IDLE_BUS  = 8'hFF;

endpackage

// File: rtl/zxuno_regport_mux.sv
// Lowest-index priority mux over the peripheral read-back bus; flags any and
// multiple simultaneous drivers.
module zxuno_regport_mux
  import zxuno_regport_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N*8-1:0] din,
  input  logic [N-1:0]   oe_n,
  output logic [7:0]     dout,
  output logic           any,
  output logic           multi
);

  always_comb begin
    dout  = ZXUNO_IDLE_BUS;
    any   = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!oe_n[i]) begin
        if (any) multi = 1'b1;
        else     dout  = din[i*8 +: 8];
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/zxuno_regport_ctrl.sv
// ZX-Uno register bus sequencer: decodes the FC3Bh/FD3Bh I/O ports, produces
// the register strobes and arbitrates peripheral read-back data to the CPU.
//
// state   | meaning
// IDLE    | waiting for an access to the address or data port
// AWR     | address-port write, latch register address (one cycle)
// AREAD   | address-port read, return the current address
// DWR     | data-port write, pulse zxuno_regwr (one cycle)
// DREAD   | data-port read, zxuno_regrd held, peripheral data returned
// RELEASE | wait for the write strobe to go away
module zxuno_regport_ctrl
  import zxuno_regport_pkg::*;
#(
  parameter int          NPERIPH   = 8,
  parameter logic [15:0] ADDR_PORT = ZXUNO_ADDR_PORT,
  parameter logic [15:0] DATA_PORT = ZXUNO_DATA_PORT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [15:0]          cpu_a,
  input  logic                 cpu_iorq_n,
  input  logic                 cpu_rd_n,
  input  logic                 cpu_wr_n,
  input  logic [7:0]           cpu_din,
  output logic [7:0]           cpu_dout,
  output logic                 cpu_oe_n,
  output logic [7:0]           zxuno_addr,
  output logic                 zxuno_regrd,
  output logic                 zxuno_regwr,
  output logic                 regaddr_changed,
  output logic [7:0]           zxuno_dout,
  input  logic [NPERIPH*8-1:0] periph_din,
  input  logic [NPERIPH-1:0]   periph_oe_n,
  output logic                 collision
);

  state_t state, state_nx;

  logic [1:0] iorq_sync, rd_sync, wr_sync;
  logic       iorq_s, rd_s, wr_s;
  logic       armed;
  logic       wr_req, rd_req, hit_a, hit_d;
  logic [7:0] mux_dout;
  logic       mux_any, mux_multi;

  // Synchronizers reset to "asserted" so a strobe held through reset must be
  // seen released before it can arm the decoder.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iorq_sync <= 2'b00;
      rd_sync   <= 2'b00;
      wr_sync   <= 2'b00;
      armed     <= 1'b0;
    end else begin
      iorq_sync <= {iorq_sync[0], cpu_iorq_n};
      rd_sync   <= {rd_sync[0], cpu_rd_n};
      wr_sync   <= {wr_sync[0], cpu_wr_n};
      armed     <= armed | iorq_s | (rd_s & wr_s);
    end
  end

  assign iorq_s = iorq_sync[1];
  assign rd_s   = rd_sync[1];
  assign wr_s   = wr_sync[1];

  assign hit_a  = (cpu_a == ADDR_PORT);
  assign hit_d  = (cpu_a == DATA_PORT);
  assign wr_req = armed && !iorq_s && !wr_s;
  assign rd_req = armed && !iorq_s && !rd_s && wr_s;

  zxuno_regport_mux #(.N(NPERIPH)) u_mux (
    .din   (periph_din),
    .oe_n  (periph_oe_n),
    .dout  (mux_dout),
    .any   (mux_any),
    .multi (mux_multi)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (wr_req && hit_a)      state_nx = ST_AWR;
        else if (wr_req && hit_d) state_nx = ST_DWR;
        else if (rd_req && hit_a) state_nx = ST_AREAD;
        else if (rd_req && hit_d) state_nx = ST_DREAD;
      end
      ST_AWR, ST_DWR:     state_nx = ST_RELEASE;
      ST_AREAD, ST_DREAD: if (rd_s || iorq_s) state_nx = ST_IDLE;
      ST_RELEASE:         if (iorq_s && wr_s) state_nx = ST_IDLE;
      default:            state_nx = ST_IDLE;
    endcase
  end

  // Outputs are registered off the next state so strobes align with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zxuno_addr      <= 8'h00;
      zxuno_dout      <= 8'h00;
      regaddr_changed <= 1'b0;
      zxuno_regwr     <= 1'b0;
      zxuno_regrd     <= 1'b0;
      cpu_dout        <= ZXUNO_IDLE_BUS;
      cpu_oe_n        <= 1'b1;
      collision       <= 1'b0;
    end else begin
      regaddr_changed <= (state_nx == ST_AWR);
      zxuno_regwr     <= (state_nx == ST_DWR);
      zxuno_regrd     <= (state_nx == ST_DREAD);
      if (state_nx == ST_AWR) zxuno_addr <= cpu_din;
      if (state_nx == ST_DWR) zxuno_dout <= cpu_din;

      if (state == ST_AREAD && state_nx == ST_AREAD) begin
        cpu_dout <= zxuno_addr;
        cpu_oe_n <= 1'b0;
      end else if (state == ST_DREAD && state_nx == ST_DREAD) begin
        cpu_dout <= mux_dout;
        cpu_oe_n <= !mux_any;
      end else begin
        cpu_dout <= ZXUNO_IDLE_BUS;
        cpu_oe_n <= 1'b1;
      end

      if (state == ST_DREAD && mux_multi) collision <= 1'b1;
    end
  end

endmodule
